clock_set_ctrl: RTL and testbench
=================================

// Module: clock_set_ctrl
// PURPOSE
//  Key-driven setting controller for the digital clock: the writer side of the alarm/time registers.
//  Converts debounced key levels into one-cycle Add/Subtract pulses for the sec/min/hour counters and
//  owns the alarm-time registers that the alarm comparator reads. Also drives the mode LEDs and a
//  per-digit blink mask for the 8-digit scanner. Sits between KEY debounce and the counter/display logic.
// PARAMETERS
//  TIMEOUT_MS      10000  ms without a key press in a set state before auto-return to RUN
//  BLINK_HALF_MS   250    half-period of the selected-field blink
//  ALARM_RST_S     5      alarm seconds reset value (0..59)
//  ALARM_RST_M     0      alarm minutes reset value (0..59)
//  ALARM_RST_H     0      alarm hours reset value (0..23)
//  REPEAT_DELAY_MS 600    hold time before auto-repeat starts (auto-repeat builds only)
//  REPEAT_RATE_MS  150    auto-repeat period (auto-repeat builds only)
// PORTS
//  Clk_50MHz   in   1  system clock
//  Reset_N     in   1  reset, asynchronous, active-low
//  tick_1ms    in   1  one-Clk-wide enable, once per ms
//  key_mode    in   1  debounced level, 1 = pressed
//  key_sel     in   1  debounced level, 1 = pressed
//  key_up      in   1  debounced level, 1 = pressed
//  key_down    in   1  debounced level, 1 = pressed
//  add_s/add_m/add_h  out 1  one-Clk increment pulse to the sec/min/hour counter
//  sub_s/sub_m/sub_h  out 1  one-Clk decrement pulse to the sec/min/hour counter
//  alarm_s     out  6  alarm seconds, 0..59
//  alarm_m     out  6  alarm minutes, 0..59
//  alarm_h     out  5  alarm hours, 0..23
//  alarm_en    out  1  alarm armed
//  mode_led    out  4  [0]=RUN [1]=SET_TIME [2]=SET_ALARM [3]=alarm_en
//  blink_mask  out  8  1 = blank digit; bits 0-1 sec, 3-4 min, 6-7 hour; bits 2 and 5 always 0
// BEHAVIOUR
//  Reset: state=RUN, field=SEC, all add_*/sub_* = 0, alarm_* = ALARM_RST_*, alarm_en=1,
//   mode_led=4'b1001, blink_mask=0, timers=0.
//  Press = rising edge of a key level, registered once; press detected the cycle after the level rises.
//  Press priority within a cycle: mode > sel > up/down. up and down pressed in the same cycle: both ignored.
//  FSM: RUN -mode-> SET_TIME -mode-> SET_ALARM -mode-> RUN. Entering either set state forces field=SEC.
//  sel (set states only): field SEC->MIN->HOUR->SEC. sel in RUN is ignored.
//  SET_TIME: up/down produces exactly one add_x/sub_x pulse for the selected field, 1 Clk after the press.
//   Counter wrap is the counter's responsibility.
//  SET_ALARM: up/down updates alarm_x by +/-1 with wrap: 59->0, 0->59 (sec/min); 23->0, 0->23 (hour).
//   No add/sub pulses are produced in this state.
//  RUN: up toggles alarm_en; down ignored; no pulses.
//  Timeout: ms counter runs in set states and clears on any press. Reaching TIMEOUT_MS -> RUN.
//   A press that arrives in the same cycle as the timeout wins: it is acted on and the counter clears.
//  Blink: in set states the digit pair of the selected field toggles every BLINK_HALF_MS.
//   The phase restarts to "visible" on every field or state change. In RUN, blink_mask=0.
//  mode_led is registered and one-hot in [2:0]; [3] mirrors alarm_en.
//  Reset mid-operation: all state returns to reset values immediately; any pulse in flight is dropped.
// CONFIGURATION
//  CLOCK_SET_AUTOREPEAT_EN defined: an up/down key held >= REPEAT_DELAY_MS in a set state generates
//   a further press every REPEAT_RATE_MS until release. Repeats count as presses for the timeout.
//  Not defined: one action per press only; the REPEAT_* parameters are unused.
// STRUCTURE
//  Package clock_set_pkg: state encoding (RUN/SET_TIME/SET_ALARM); field encoding (SEC/MIN/HOUR);
//   the constants 59 and 23 as wrap limits; the blink_mask bit positions for each field.
//  Sub-module clock_set_keyedge (one instance per key): edge detect plus optional auto-repeat,
//   producing a one-Clk press strobe.
// TESTING
//  1. Reset -> alarm=00:00:05, alarm_en=1, mode_led=4'b1001, all add/sub=0, blink_mask=0.
//  2. mode, up x3 -> three add_s pulses of 1 Clk each; mode, sel, up -> alarm_m=1, no add/sub pulse.
//  3. SET_ALARM with field HOUR at 0, down -> alarm_h=23; field SEC at 59, up -> alarm_s=0.
//  4. SET_TIME with TIMEOUT_MS=5 and no keys -> RUN after 5 tick_1ms; a press on the tick cycle keeps SET_TIME.
//  5. up and down pressed together -> no pulse, alarm unchanged; mode+up together -> state advances only.
//  6. CLOCK_SET_AUTOREPEAT_EN, delay 600/rate 150: hold up 1000 ms in SET_TIME -> 1+2=3 add_s pulses.

Source files
------------

// File: rtl/clock_set_ctrl_pkg.sv
// clock_set_pkg: state/field encodings, wrap limits and blink digit masks for the clock setting controller.
package clock_set_pkg;
  typedef enum logic [1:0] {RUN, SET_TIME, SET_ALARM} state_e;
  typedef enum logic [1:0] {SEC, MIN, HOUR} field_e;
  localparam logic [5:0] MS_MAX = 6'd59;
  localparam logic [4:0] H_MAX = 5'd23;
  localparam logic [7:0] MASK_SEC = 8'b0000_0011;
  localparam logic [7:0] MASK_MIN = 8'b0001_1000;
  localparam logic [7:0] MASK_HOUR = 8'b1100_0000;
  function automatic logic [7:0] field_mask(input field_e f);
    return f == SEC ? MASK_SEC : f == MIN ? MASK_MIN : MASK_HOUR;
  endfunction
  function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic up, input logic [5:0] lim);
    return up ? (v == lim ? 6'd0 : v + 6'd1) : (v == 6'd0 ? lim : v - 6'd1);
  endfunction
endpackage

// File: rtl/clock_set_ctrl_if.sv
// clock_set_ctrl_if: key/tick inputs and counter/alarm/display outputs of the clock setting controller.
interface clock_set_ctrl_if;
  logic tick_1ms, key_mode, key_sel, key_up, key_down;
  logic add_s, add_m, add_h, sub_s, sub_m, sub_h;
  logic [5:0] alarm_s, alarm_m;
  logic [4:0] alarm_h;
  logic alarm_en;
  logic [3:0] mode_led;
  logic [7:0] blink_mask;
  modport master(
    output tick_1ms, key_mode, key_sel, key_up, key_down,
    input add_s, add_m, add_h, sub_s, sub_m, sub_h, alarm_s, alarm_m, alarm_h, alarm_en, mode_led, blink_mask
  );
  modport slave(
    input tick_1ms, key_mode, key_sel, key_up, key_down,
    output add_s, add_m, add_h, sub_s, sub_m, sub_h, alarm_s, alarm_m, alarm_h, alarm_en, mode_led, blink_mask
  );
endinterface

// File: rtl/clock_set_ctrl_keyedge.sv
// clock_set_keyedge: registered rising-edge press strobe for one key; auto-repeat when CLOCK_SET_AUTOREPEAT_EN is defined.
module clock_set_keyedge #(
  parameter int REPEAT_DELAY_MS = 600,
  parameter int REPEAT_RATE_MS = 150
) (
  input  logic Clk_50MHz,
  input  logic Reset_N,
  input  logic tick_i,
  input  logic rpt_en_i,
  input  logic key_i,
  output logic press_o
);
  logic lvl_q, press_q, press_d;
`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY_MS + REPEAT_RATE_MS + 1);
  logic [RW-1:0] hold_q, hold_d;
  logic rpt;
  // after the hold delay the first repeat lands one full rate period later, then every period
  always_comb begin
    hold_d = hold_q;
    rpt = 1'b0;
    if (!key_i || !rpt_en_i) hold_d = '0;
    else if (tick_i) begin
      rpt = hold_q == RW'(REPEAT_DELAY_MS + REPEAT_RATE_MS - 1);
      hold_d = rpt ? RW'(REPEAT_DELAY_MS) : hold_q + RW'(1);
    end
  end
  always_ff @(posedge Clk_50MHz or negedge Reset_N)
    if (!Reset_N) hold_q <= '0;
    else hold_q <= hold_d;
  assign press_d = (key_i & ~lvl_q) | rpt;
`else
  logic unused_rpt;
  assign unused_rpt = tick_i ^ rpt_en_i ^ (REPEAT_DELAY_MS + REPEAT_RATE_MS != 0);
  assign press_d = key_i & ~lvl_q;
`endif
  always_ff @(posedge Clk_50MHz or negedge Reset_N)
    if (!Reset_N) begin
      lvl_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      lvl_q <= key_i;
      press_q <= press_d;
    end
  assign press_o = press_q;
endmodule

// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl: key-driven time/alarm setting FSM with add/sub pulses, alarm registers, mode LEDs and blink mask.
// Optional auto-repeat of held up/down keys via CLOCK_SET_AUTOREPEAT_EN.
module clock_set_ctrl
  import clock_set_pkg::*;
#(
  parameter int TIMEOUT_MS = 10000,
  parameter int BLINK_HALF_MS = 250,
  parameter int ALARM_RST_S = 5,
  parameter int ALARM_RST_M = 0,
  parameter int ALARM_RST_H = 0,
  parameter int REPEAT_DELAY_MS = 600,
  parameter int REPEAT_RATE_MS = 150
) (
  input logic Clk_50MHz,
  input logic Reset_N,
  clock_set_ctrl_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT_MS + 1);
  localparam int BW = $clog2(BLINK_HALF_MS + 1);
  state_e state_q, state_d;
  field_e field_q, field_d;
  logic [5:0] alarm_s_q, alarm_s_d, alarm_m_q, alarm_m_d;
  logic [4:0] alarm_h_q, alarm_h_d;
  logic alarm_en_q, alarm_en_d, phase_q, phase_d, tick;
  logic [2:0] add_q, add_d, sub_q, sub_d, fsel;
  logic [TW-1:0] to_q, to_d;
  logic [BW-1:0] bl_q, bl_d;
  logic [3:0] led_q, led_d, keys, press;
  assign tick = bus.tick_1ms;
  assign keys = {bus.key_down, bus.key_up, bus.key_sel, bus.key_mode};
  assign fsel = 3'b001 << field_q;
  for (genvar k = 0; k < 4; k++) begin : g_key
    clock_set_keyedge #(.REPEAT_DELAY_MS(REPEAT_DELAY_MS), .REPEAT_RATE_MS(REPEAT_RATE_MS)) u_edge (
      .Clk_50MHz(Clk_50MHz), .Reset_N(Reset_N), .tick_i(tick),
      .rpt_en_i(k >= 2 && state_q != RUN), .key_i(keys[k]), .press_o(press[k])
    );
  end
  // only the highest-priority press of a cycle is acted on; a press beats a simultaneous timeout
  always_comb begin
    state_d = state_q;
    field_d = field_q;
    alarm_s_d = alarm_s_q;
    alarm_m_d = alarm_m_q;
    alarm_h_d = alarm_h_q;
    alarm_en_d = alarm_en_q;
    add_d = '0;
    sub_d = '0;
    if (press[0]) begin
      state_d = state_q == RUN ? SET_TIME : state_q == SET_TIME ? SET_ALARM : RUN;
      field_d = SEC;
    end else if (press[1]) begin
      if (state_q != RUN) field_d = field_q == SEC ? MIN : field_q == MIN ? HOUR : SEC;
    end else if (press[2] ^ press[3]) begin
      if (state_q == RUN) alarm_en_d = alarm_en_q ^ press[2];
      else if (state_q == SET_TIME) begin
        add_d = press[2] ? fsel : '0;
        sub_d = press[3] ? fsel : '0;
      end else begin
        if (field_q == SEC) alarm_s_d = wrap_step(alarm_s_q, press[2], MS_MAX);
        if (field_q == MIN) alarm_m_d = wrap_step(alarm_m_q, press[2], MS_MAX);
        if (field_q == HOUR) alarm_h_d = 5'(wrap_step({1'b0, alarm_h_q}, press[2], {1'b0, H_MAX}));
      end
    end else if (state_q != RUN && tick && to_q == TW'(TIMEOUT_MS - 1)) state_d = RUN;
    to_d = (state_d == RUN || |press) ? '0 : to_q + TW'(tick);
    bl_d = bl_q;
    phase_d = phase_q;
    if (state_d == RUN || state_d != state_q || field_d != field_q) begin
      bl_d = '0;
      phase_d = 1'b0;
    end else if (tick) begin
      bl_d = bl_q == BW'(BLINK_HALF_MS - 1) ? '0 : bl_q + BW'(1);
      phase_d = phase_q ^ (bl_q == BW'(BLINK_HALF_MS - 1));
    end
    led_d = {alarm_en_d, state_d == SET_ALARM, state_d == SET_TIME, state_d == RUN};
  end
  always_ff @(posedge Clk_50MHz or negedge Reset_N)
    if (!Reset_N) begin
      state_q <= RUN;
      field_q <= SEC;
      alarm_s_q <= 6'(ALARM_RST_S);
      alarm_m_q <= 6'(ALARM_RST_M);
      alarm_h_q <= 5'(ALARM_RST_H);
      alarm_en_q <= 1'b1;
      add_q <= '0;
      sub_q <= '0;
      to_q <= '0;
      bl_q <= '0;
      phase_q <= 1'b0;
      led_q <= 4'b1001;
    end else begin
      state_q <= state_d;
      field_q <= field_d;
      alarm_s_q <= alarm_s_d;
      alarm_m_q <= alarm_m_d;
      alarm_h_q <= alarm_h_d;
      alarm_en_q <= alarm_en_d;
      add_q <= add_d;
      sub_q <= sub_d;
      to_q <= to_d;
      bl_q <= bl_d;
      phase_q <= phase_d;
      led_q <= led_d;
    end
  assign {bus.add_h, bus.add_m, bus.add_s} = add_q;
  assign {bus.sub_h, bus.sub_m, bus.sub_s} = sub_q;
  assign bus.alarm_s = alarm_s_q;
  assign bus.alarm_m = alarm_m_q;
  assign bus.alarm_h = alarm_h_q;
  assign bus.alarm_en = alarm_en_q;
  assign bus.mode_led = led_q;
  assign bus.blink_mask = (state_q != RUN && phase_q) ? field_mask(field_q) : '0;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// tb_clock_set_ctrl: directed and randomized key/tick stimulus checked every cycle against a behavioural model.
module tb_clock_set_ctrl;
  localparam int TO = 5;
  localparam int BL = 3;
  typedef struct {
    int st, fld, as_, am, ah, idle, bms;
    bit en;
    bit [3:0] prev, pend;
    bit [2:0] add, sub;
  } mdl_t;
  logic clk = 1'b0;
  logic rst_n;
  bit [3:0] keys;
  bit tick;
  int checks = 0;
  int errors = 0;
  int n_adds = 0;
  int n_pulse = 0;
  int a0, p0;
  mdl_t m;
  clock_set_ctrl_if bus();
  assign bus.tick_1ms = tick;
  assign bus.key_mode = keys[0];
  assign bus.key_sel = keys[1];
  assign bus.key_up = keys[2];
  assign bus.key_down = keys[3];
  clock_set_ctrl #(.TIMEOUT_MS(TO), .BLINK_HALF_MS(BL)) dut (.Clk_50MHz(clk), .Reset_N(rst_n), .bus(bus));
  always #5 clk = ~clk;
  function automatic mdl_t mreset();
    mdl_t r;
    r.st = 0; r.fld = 0; r.as_ = 5; r.am = 0; r.ah = 0; r.idle = 0; r.bms = 0;
    r.en = 1'b1; r.prev = '0; r.pend = '0; r.add = '0; r.sub = '0;
    return r;
  endfunction
  function automatic mdl_t step(mdl_t s, bit [3:0] k, bit t);
    mdl_t n;
    bit [3:0] p;
    int d;
    n = s;
    p = s.pend;
    n.pend = k & ~s.prev;
    n.prev = k;
    n.add = '0;
    n.sub = '0;
    d = p[2] ? 1 : -1;
    if (p[0]) begin n.st = (s.st + 1) % 3; n.fld = 0; end
    else if (p[1]) begin if (s.st != 0) n.fld = (s.fld + 1) % 3; end
    else if (p[2] != p[3]) begin
      if (s.st == 0) begin if (p[2]) n.en = ~s.en; end
      else if (s.st == 1) begin if (p[2]) n.add[s.fld] = 1'b1; else n.sub[s.fld] = 1'b1; end
      else if (s.fld == 0) n.as_ = (s.as_ + d + 60) % 60;
      else if (s.fld == 1) n.am = (s.am + d + 60) % 60;
      else n.ah = (s.ah + d + 24) % 24;
    end
    if (p != 0 || n.st == 0) n.idle = 0;
    else if (t) begin
      n.idle = s.idle + 1;
      if (n.idle == TO) begin n.st = 0; n.idle = 0; end
    end
    if (n.st == 0 || n.st != s.st || n.fld != s.fld) n.bms = 0;
    else if (t) n.bms = s.bms + 1;
    return n;
  endfunction
  function automatic logic [35:0] expv(mdl_t s);
    logic [3:0] led;
    logic [7:0] bm;
    led = {s.en, s.st == 2, s.st == 1, s.st == 0};
    bm = (s.st != 0 && (s.bms / BL) % 2 == 1) ? 8'd3 << (3 * s.fld) : 8'd0;
    return {s.add, s.sub, 6'(s.as_), 6'(s.am), 5'(s.ah), s.en, led, bm};
  endfunction
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m <= mreset();
    else m <= step(m, keys, tick);
  always @(negedge clk) begin
    if (bus.add_s) n_adds <= n_adds + 1;
    if (bus.add_s | bus.add_m | bus.add_h | bus.sub_s | bus.sub_m | bus.sub_h) n_pulse <= n_pulse + 1;
  end
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask
  task automatic cyc(int n);
    logic [35:0] dv, ev;
    repeat (n) begin
      @(negedge clk);
      #1;
      dv = {bus.add_h, bus.add_m, bus.add_s, bus.sub_h, bus.sub_m, bus.sub_s, bus.alarm_s, bus.alarm_m,
            bus.alarm_h, bus.alarm_en, bus.mode_led, bus.blink_mask};
      ev = expv(m);
      checks++;
      if (dv !== ev) begin
        errors++;
        $display("FAIL model t=%0t got %h want %h", $time, dv, ev);
      end
    end
  endtask
  task automatic press(bit [3:0] k);
    keys = k;
    cyc(2);
    keys = '0;
    cyc(4);
  endtask
  task automatic tick_n(int n);
    repeat (n) begin
      tick = 1'b1;
      cyc(1);
      tick = 1'b0;
      cyc(1);
    end
  endtask
  initial begin
    rst_n = 1'b0;
    keys = '0;
    tick = 1'b0;
    repeat (2) @(negedge clk);
    cyc(1);
    chk("rst_alarm_s", int'(bus.alarm_s), 5);
    chk("rst_alarm_m", int'(bus.alarm_m), 0);
    chk("rst_alarm_h", int'(bus.alarm_h), 0);
    chk("rst_mode_led", int'(bus.mode_led), 4'b1001);
    chk("rst_blink", int'(bus.blink_mask), 0);
    chk("rst_pulses", int'({bus.add_s, bus.add_m, bus.add_h, bus.sub_s, bus.sub_m, bus.sub_h}), 0);
    rst_n = 1'b1;
    cyc(2);
    press(4'b0001);
    chk("set_time_led", int'(bus.mode_led), 4'b1010);
    a0 = n_adds;
    repeat (3) press(4'b0100);
    chk("three_add_s", n_adds - a0, 3);
    press(4'b0001);
    press(4'b0010);
    p0 = n_pulse;
    press(4'b0100);
    chk("alarm_m_up", int'(bus.alarm_m), 1);
    chk("no_pulse_alarm", n_pulse - p0, 0);
    tick_n(3);
    chk("blink_min", int'(bus.blink_mask), 8'h18);
    press(4'b0001);
    chk("run_blink", int'(bus.blink_mask), 0);
    press(4'b0001);
    press(4'b0001);
    press(4'b0010);
    press(4'b0010);
    press(4'b1000);
    chk("hour_wrap_down", int'(bus.alarm_h), 23);
    chk("mdl_hour_wrap", m.ah, 23);
    press(4'b0001);
    press(4'b0001);
    press(4'b0001);
    repeat (6) press(4'b1000);
    chk("sec_wrap_down", int'(bus.alarm_s), 59);
    press(4'b0100);
    chk("sec_wrap_up", int'(bus.alarm_s), 0);
    p0 = n_pulse;
    press(4'b1100);
    chk("updown_alarm", int'(bus.alarm_s), 0);
    chk("updown_pulse", n_pulse - p0, 0);
    press(4'b0001);
    press(4'b0101);
    chk("mode_up_led", int'(bus.mode_led), 4'b1010);
    tick_n(TO - 1);
    chk("before_timeout", int'(bus.mode_led), 4'b1010);
    tick_n(1);
    chk("timeout_run", int'(bus.mode_led), 4'b1001);
    press(4'b0001);
    tick_n(TO - 1);
    keys = 4'b0010;
    cyc(1);
    tick = 1'b1;
    cyc(1);
    tick = 1'b0;
    keys = '0;
    cyc(3);
    chk("press_beats_timeout", int'(bus.mode_led), 4'b1010);
    chk("mdl_field_min", m.fld, 1);
    press(4'b0001);
    press(4'b0001);
    press(4'b0100);
    chk("alarm_off_led", int'(bus.mode_led), 4'b0001);
    press(4'b0100);
    chk("alarm_on_led", int'(bus.mode_led), 4'b1001);
    press(4'b0001);
    keys = 4'b0100;
    @(posedge clk);
    #2 rst_n = 1'b0;
    keys = '0;
    cyc(2);
    chk("rst_drop_pulse", int'(bus.add_s), 0);
    chk("rst_led", int'(bus.mode_led), 4'b1001);
    rst_n = 1'b1;
    cyc(2);
    for (int i = 0; i < 4000; i++) begin
      for (int j = 0; j < 4; j++) if ($urandom_range(0, 7) == 0) keys[j] = ~keys[j];
      tick = $urandom_range(0, 2) == 0;
      rst_n = $urandom_range(0, 499) != 0;
      cyc(1);
    end
    rst_n = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
